// File: rtl/multicycle_control.sv
// multicycle_control: state-machine control for a multicycle RV32I datapath over one shared
// memory port, with memory wait-state timeout, sticky trap and cycle/retired-instruction counters.

`ifndef MULTICYCLE_CONTROL_DEFS
`define MULTICYCLE_CONTROL_DEFS
`define CTL_ALU_A_RS1        1'b0
`define CTL_ALU_A_PC         1'b1
`define CTL_ALU_B_RS2        1'b0
`define CTL_ALU_B_IMM        1'b1
`define CTL_ALU_ADD          2'd0
`define CTL_ALU_OP           2'd1
`define CTL_ALU_OP_IMM       2'd2
`define CTL_ALU_BRANCH       2'd3
`define CTL_WRITEBACK_ALU    3'd0
`define CTL_WRITEBACK_DATA   3'd1
`define CTL_WRITEBACK_IMM    3'd2
`define CTL_WRITEBACK_PC4    3'd3
`define CTL_PC_PC4           2'd0
`define CTL_PC_PC_IMM        2'd1
`define CTL_PC_RS1_IMM       2'd2
`endif

module multicycle_control #(
    parameter int unsigned STALL_TIMEOUT = 16,
    parameter int unsigned COUNT_WIDTH   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [6:0]             inst_opcode,
    input  logic                   take_branch,
    input  logic                   mem_ready,
    output logic                   pc_write_enable,
    output logic                   ir_write_enable,
    output logic                   regfile_write_enable,
    output logic                   alu_operand_a_select,
    output logic                   alu_operand_b_select,
    output logic [1:0]             alu_op_type,
    output logic                   mem_read_enable,
    output logic                   mem_write_enable,
    output logic                   mem_addr_select,
    output logic [2:0]             reg_writeback_select,
    output logic [1:0]             next_pc_select,
    output logic                   trap,
    output logic                   trap_timeout,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instret_count
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    // Wait counter only needs to hold 0..STALL_TIMEOUT-1; the next low cycle traps.
    localparam int unsigned        WAIT_W    = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                trap_timeout_next;
    logic                stall_expired;
    logic                opcode_legal;

    assign stall_expired = (STALL_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        unique case (inst_opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: opcode_legal = 1'b1;
            default:                                        opcode_legal = 1'b0;
        endcase
    end

    // Next state and control outputs, decoded from state, opcode and handshake inputs.
    always_comb begin
        state_next           = state;
        wait_next            = '0;
        trap_timeout_next    = trap_timeout;
        pc_write_enable      = 1'b0;
        ir_write_enable      = 1'b0;
        regfile_write_enable = 1'b0;
        alu_operand_a_select = `CTL_ALU_A_RS1;
        alu_operand_b_select = `CTL_ALU_B_RS2;
        alu_op_type          = `CTL_ALU_ADD;
        mem_read_enable      = 1'b0;
        mem_write_enable     = 1'b0;
        mem_addr_select      = 1'b0;
        reg_writeback_select = `CTL_WRITEBACK_ALU;
        next_pc_select       = `CTL_PC_PC4;
        trap                 = 1'b0;

        case (state)
            ST_START: state_next = ST_FETCH;

            ST_FETCH: begin
                mem_read_enable = 1'b1;
                if (mem_ready) begin
                    ir_write_enable = 1'b1;
                    state_next      = ST_DECODE;
                end else if (stall_expired) begin
                    state_next        = ST_TRAP;
                    trap_timeout_next = 1'b1;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end

            ST_DECODE: begin
                if (opcode_legal) begin
                    state_next = ST_EXECUTE;
                end else begin
                    state_next        = ST_TRAP;
                    trap_timeout_next = 1'b0;
                end
            end

            ST_EXECUTE: begin
                case (inst_opcode)
                    OPC_LOAD, OPC_STORE: begin
                        alu_operand_b_select = `CTL_ALU_B_IMM;
                        state_next           = ST_MEM;
                    end
                    OPC_JALR: begin
                        alu_operand_b_select = `CTL_ALU_B_IMM;
                        state_next           = ST_WRITEBACK;
                    end
                    OPC_OP_IMM: begin
                        alu_operand_b_select = `CTL_ALU_B_IMM;
                        alu_op_type          = `CTL_ALU_OP_IMM;
                        state_next           = ST_WRITEBACK;
                    end
                    OPC_OP: begin
                        alu_op_type = `CTL_ALU_OP;
                        state_next  = ST_WRITEBACK;
                    end
                    OPC_AUIPC, OPC_JAL: begin
                        alu_operand_a_select = `CTL_ALU_A_PC;
                        alu_operand_b_select = `CTL_ALU_B_IMM;
                        state_next           = ST_WRITEBACK;
                    end
                    OPC_LUI: state_next = ST_WRITEBACK;
                    OPC_BRANCH: begin
                        alu_op_type     = `CTL_ALU_BRANCH;
                        pc_write_enable = 1'b1;
                        next_pc_select  = take_branch ? `CTL_PC_PC_IMM : `CTL_PC_PC4;
                        state_next      = ST_FETCH;
                    end
                    OPC_MISC_MEM: begin
                        pc_write_enable = 1'b1;
                        state_next      = ST_FETCH;
                    end
                    default: state_next = ST_TRAP;
                endcase
            end

            ST_MEM: begin
                mem_addr_select  = 1'b1;
                mem_read_enable  = (inst_opcode == OPC_LOAD);
                mem_write_enable = (inst_opcode == OPC_STORE);
                if (mem_ready) begin
                    if (inst_opcode == OPC_LOAD) begin
                        state_next = ST_WRITEBACK;
                    end else begin
                        pc_write_enable = 1'b1;
                        state_next      = ST_FETCH;
                    end
                end else if (stall_expired) begin
                    state_next        = ST_TRAP;
                    trap_timeout_next = 1'b1;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end

            ST_WRITEBACK: begin
                regfile_write_enable = 1'b1;
                pc_write_enable      = 1'b1;
                case (inst_opcode)
                    OPC_LOAD:           reg_writeback_select = `CTL_WRITEBACK_DATA;
                    OPC_LUI:            reg_writeback_select = `CTL_WRITEBACK_IMM;
                    OPC_JAL, OPC_JALR:  reg_writeback_select = `CTL_WRITEBACK_PC4;
                    default:            reg_writeback_select = `CTL_WRITEBACK_ALU;
                endcase
                case (inst_opcode)
                    OPC_JAL:  next_pc_select = `CTL_PC_PC_IMM;
                    OPC_JALR: next_pc_select = `CTL_PC_RS1_IMM;
                    default:  next_pc_select = `CTL_PC_PC4;
                endcase
                state_next = ST_FETCH;
            end

            ST_TRAP: trap = 1'b1;

            default: state_next = ST_START;
        endcase
    end

    // State, wait counter, trap cause and performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_START;
            wait_cnt      <= '0;
            trap_timeout  <= 1'b0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_next;
            trap_timeout <= trap_timeout_next;
            cycle_count  <= cycle_count + COUNT_WIDTH'(1);
            if (pc_write_enable) begin
                instret_count <= instret_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked cycle by cycle against an
// instruction-level schedule model (phase lengths from wait counts) plus counter model.

module tb_multicycle_control;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;
    localparam int          CMOD    = 1 << CW;

    localparam logic [6:0] LOAD = 7'b0000011, MISC = 7'b0001111, OPIMM = 7'b0010011,
                           AUIPC = 7'b0010111, STORE = 7'b0100011, OP = 7'b0110011,
                           LUI = 7'b0110111, BRANCH = 7'b1100011, JALR = 7'b1100111,
                           JAL = 7'b1101111;

    logic          clock = 1'b0;
    logic          reset;
    logic [6:0]    inst_opcode;
    logic          take_branch;
    logic          mem_ready;
    logic          pc_write_enable, ir_write_enable, regfile_write_enable;
    logic          alu_operand_a_select, alu_operand_b_select;
    logic [1:0]    alu_op_type;
    logic          mem_read_enable, mem_write_enable, mem_addr_select;
    logic [2:0]    reg_writeback_select;
    logic [1:0]    next_pc_select;
    logic          trap, trap_timeout;
    logic [CW-1:0] cycle_count, instret_count;
    logic [15:0]   obs;

    int n_cmp = 0;
    int n_err = 0;
    int model_cycle;
    int exp_instret;

    multicycle_control #(.STALL_TIMEOUT(TIMEOUT), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .inst_opcode(inst_opcode), .take_branch(take_branch),
        .mem_ready(mem_ready), .pc_write_enable(pc_write_enable), .ir_write_enable(ir_write_enable),
        .regfile_write_enable(regfile_write_enable), .alu_operand_a_select(alu_operand_a_select),
        .alu_operand_b_select(alu_operand_b_select), .alu_op_type(alu_op_type),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_addr_select(mem_addr_select), .reg_writeback_select(reg_writeback_select),
        .next_pc_select(next_pc_select), .trap(trap), .trap_timeout(trap_timeout),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clock = ~clock;

    assign obs = {pc_write_enable, ir_write_enable, regfile_write_enable, alu_operand_a_select,
                  alu_operand_b_select, alu_op_type, mem_read_enable, mem_write_enable,
                  mem_addr_select, reg_writeback_select, next_pc_select, trap};

    // Every non-reset clock edge is one counted cycle.
    always @(posedge clock or posedge reset) begin
        if (reset) model_cycle <= 0;
        else       model_cycle <= model_cycle + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] bundle(input logic pc, input logic ir, input logic rf,
                                           input logic a, input logic b, input logic [1:0] alu,
                                           input logic mr, input logic mw, input logic ma,
                                           input logic [2:0] wb, input logic [1:0] npc,
                                           input logic tr);
        return {pc, ir, rf, a, b, alu, mr, mw, ma, wb, npc, tr};
    endfunction

    task automatic drive(input logic r, input logic b);
        @(negedge clock);
        mem_ready   = r;
        take_branch = b;
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_cycles"}, 32'(cycle_count), 32'(model_cycle % CMOD));
        check({tag, "_instret"}, 32'(instret_count), 32'(exp_instret % CMOD));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        take_branch = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_instret = 0;
        #1;
        check("start", 32'(obs), 32'(bundle(0,0,0,0,0,2'd0,0,0,0,3'd0,2'd0,0)));
        check("start_tt", 32'(trap_timeout), 32'(0));
        check_counters("start");
    endtask

    task automatic do_fetch(input int wf);
        logic rdy;
        for (int i = 0; i <= wf; i++) begin
            rdy = (i == wf);
            drive(rdy, rnd());
            if (i == 0) check_counters("fetch");
            check("fetch", 32'(obs), 32'(bundle(0,rdy,0,0,0,2'd0,1,0,0,3'd0,2'd0,0)));
        end
    endtask

    task automatic do_decode(input logic [6:0] op);
        inst_opcode = op;
        drive(rnd(), rnd());
        check("decode", 32'(obs), 32'(bundle(0,0,0,0,0,2'd0,0,0,0,3'd0,2'd0,0)));
    endtask

    task automatic do_exec(input logic [6:0] op, input logic br);
        logic a, b, pc;
        logic [1:0] alu, npc;
        a = 0; b = 0; alu = 2'd0;
        case (op)
            LOAD, STORE, JALR: b = 1;
            OPIMM:             begin b = 1; alu = 2'd2; end
            OP:                alu = 2'd1;
            AUIPC, JAL:        begin a = 1; b = 1; end
            BRANCH:            alu = 2'd3;
            default:           ;
        endcase
        pc  = (op == BRANCH) || (op == MISC);
        npc = (op == BRANCH && br) ? 2'd1 : 2'd0;
        drive(rnd(), br);
        check("execute", 32'(obs), 32'(bundle(pc,0,0,a,b,alu,0,0,0,3'd0,npc,0)));
    endtask

    task automatic do_mem(input logic [6:0] op, input int wm);
        logic rdy, ld, st;
        ld = (op == LOAD);
        st = (op == STORE);
        for (int i = 0; i <= wm; i++) begin
            rdy = (i == wm);
            drive(rdy, rnd());
            check("mem", 32'(obs), 32'(bundle(st && rdy,0,0,0,0,2'd0,ld,st,1,3'd0,2'd0,0)));
        end
    endtask

    task automatic do_wb(input logic [6:0] op);
        logic [2:0] wb;
        logic [1:0] npc;
        wb  = (op == LOAD) ? 3'd1 : (op == LUI) ? 3'd2 : (op == JAL || op == JALR) ? 3'd3 : 3'd0;
        npc = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
        drive(rnd(), rnd());
        check("writeback", 32'(obs), 32'(bundle(1,0,1,0,0,2'd0,0,0,0,wb,npc,0)));
    endtask

    // One instruction: fetch(wf waits), decode, execute, optional mem(wm waits), optional writeback.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input logic br);
        do_fetch(wf);
        do_decode(op);
        do_exec(op, br);
        if (op == LOAD || op == STORE) do_mem(op, wm);
        if (!(op == BRANCH || op == MISC || op == STORE)) do_wb(op);
        exp_instret++;
    endtask

    task automatic check_trap(input logic cause, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(rnd(), rnd());
            check("trap_out", 32'(obs), 32'(bundle(0,0,0,0,0,2'd0,0,0,0,3'd0,2'd0,1)));
            check("trap_cause", 32'(trap_timeout), 32'(cause));
            check_counters("trap");
        end
    endtask

    logic [6:0] legal_ops [10] = '{LOAD, MISC, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL};

    initial begin
        inst_opcode = 7'h00;
        apply_reset();

        // Directed: OP, stalled LOAD, branches taken / not taken.
        run_instr(OP, 0, 0, 0);
        run_instr(LOAD, 3, 2, 0);
        run_instr(BRANCH, 0, 0, 1);
        run_instr(BRANCH, 0, 0, 0);
        run_instr(JAL, 0, 0, 0);
        run_instr(JALR, 1, 0, 0);
        run_instr(LUI, 0, 0, 0);
        run_instr(STORE, 0, 3, 0);

        // 16 MISC_MEM retires wrap a 4-bit instret counter back to its start value.
        apply_reset();
        for (int i = 0; i < 16; i++) run_instr(MISC, 0, 0, rnd());
        do_fetch(0);
        check("instret_wrap", 32'(instret_count), 32'(0));
        do_decode(OP);
        do_exec(OP, 0);
        do_wb(OP);
        exp_instret++;

        // Random instruction stream with waits up to the last allowed cycle.
        for (int n = 0; n < 60; n++) begin
            run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, TIMEOUT - 1),
                      $urandom_range(0, TIMEOUT - 1), rnd());
        end

        // Illegal opcode traps from DECODE; trap is absorbing until reset.
        run_instr(OPIMM, 0, 0, 0);
        do_fetch(1);
        do_decode(7'b1111111);
        check_trap(1'b0, 6);
        apply_reset();

        // STORE held in MEM for TIMEOUT low cycles traps on timeout.
        run_instr(AUIPC, 0, 0, 0);
        do_fetch(0);
        do_decode(STORE);
        do_exec(STORE, 0);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            drive(1'b0, rnd());
            check("mem_stall", 32'(obs), 32'(bundle(0,0,0,0,0,2'd0,0,1,1,3'd0,2'd0,0)));
        end
        check_trap(1'b1, 4);
        apply_reset();

        // FETCH stalled for TIMEOUT low cycles also traps on timeout.
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            drive(1'b0, rnd());
            check("fetch_stall", 32'(obs), 32'(bundle(0,0,0,0,0,2'd0,1,0,0,3'd0,2'd0,0)));
        end
        check_trap(1'b1, 3);
        apply_reset();

        // Reset mid-MEM store drops the write request without waiting for a clock edge.
        run_instr(OP, 0, 0, 0);
        do_fetch(0);
        do_decode(STORE);
        do_exec(STORE, 0);
        drive(1'b0, 1'b0);
        check("mid_mem_we", 32'(mem_write_enable), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("async_we", 32'(mem_write_enable), 32'(0));
        check("async_pc_we", 32'(pc_write_enable), 32'(0));
        check("async_instret", 32'(instret_count), 32'(0));
        check("async_cycles", 32'(cycle_count), 32'(0));
        apply_reset();
        run_instr(LOAD, 0, 0, 0);
        do_fetch(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
